alu_op_sequencer: RTL and testbench
===================================

// Module: alu_op_sequencer
// PURPOSE
//  Sequences the ALU datapath from a front-panel push button: debounces the button, steps the opcode and waits out ALU latency.
//  Then captures the ALU answer and flags it valid for one cycle.
//  Sits between board I/O (button, optional direct opcode load) and ALU (drives opcode, samples answer).
// PARAMETERS
//  DATA_WIDTH       8   width of ALU answer / captured result
//  OPCODE_WIDTH     4   width of opcode bus to ALU
//  NUM_OPS          10  legal opcodes 0..NUM_OPS-1; step wraps NUM_OPS-1 -> 0
//  DEBOUNCE_CYCLES  16  consecutive stable synced cycles required to accept a level change (>=1)
//  ALU_LATENCY      1   clocks from opcode change to valid ALU answer (>=1)
// PORTS
//  clk          in   1             single clock, all logic rising-edge
//  reset        in   1             asynchronous, active-high; clears all state immediately
//  button       in   1             raw async push button, active-high
//  load_en      in   1             sync direct-load strobe
//  load_op      in   OPCODE_WIDTH  opcode to load when load_en=1
//  alu_ans      in   DATA_WIDTH    answer from ALU datapath
//  opcode       out  OPCODE_WIDTH  opcode to ALU, registered
//  result       out  DATA_WIDTH    captured answer, holds until next capture
//  result_valid out  1             1-cycle pulse when result updated
//  busy         out  1             high in WAIT/CAPTURE; step/load requests dropped
//  load_err     out  1             1-cycle pulse: load_op >= NUM_OPS (load ignored)
// BEHAVIOUR
//  Reset: opcode=0, result=0, result_valid=0, busy=0, load_err=0, state=IDLE, sync/debounce regs=0, counters=0.
//  Sync: button through 2 flops -> btn_s. Debounce: cnt increments while btn_s != stable, clears when equal.
//   When cnt reaches DEBOUNCE_CYCLES-1 with btn_s still != stable: stable<=btn_s, cnt<=0.
//  press = stable & ~stable_d (rising edge, 1 cycle). Release generates nothing. Glitch shorter than DEBOUNCE_CYCLES: no press.
//  FSM (alu_seq_state_t): IDLE, WAIT, CAPTURE.
//   IDLE: load_en & load_op<NUM_OPS -> opcode<=load_op, wcnt<=ALU_LATENCY-1, ->WAIT.
//         load_en & load_op>=NUM_OPS -> load_err pulse, opcode unchanged, stay IDLE.
//         else press -> opcode<=(opcode==NUM_OPS-1)?0:opcode+1, wcnt<=ALU_LATENCY-1, ->WAIT.
//         load_en and press same cycle: load wins, press discarded (even if load errors).
//   WAIT: busy=1; wcnt==0 -> CAPTURE else wcnt--.
//   CAPTURE: busy=1; result<=alu_ans, result_valid<=1 (registered, visible next cycle), ->IDLE.
//  Latency: opcode changes at edge k; result_valid high in cycle k+ALU_LATENCY+1, result holds answer from opcode(k).
//  Button held high from cycle 0: press at cycle 3+DEBOUNCE_CYCLES, opcode updates next edge.
//  press/load_en during WAIT/CAPTURE: dropped, not queued; debouncer keeps running.
//  busy derived combinationally from state; result_valid, load_err registered.
//  Reset mid-operation: async clear of all regs incl. debouncer; no result_valid for aborted op; press needs fresh debounce after release.
//  Arithmetic: opcode compare/increment at OPCODE_WIDTH, unsigned; wcnt width $clog2(ALU_LATENCY+1).
// STRUCTURE
//  alu_pkg: typedef enum alu_seq_state_t {IDLE,WAIT,CAPTURE}; opcode localparams (OP_ADD..), NUM_OPS default.
//  Sub-module button_debouncer (clk, reset, btn_raw, btn_stable, btn_press): synchroniser + debounce counter + edge detect.
//  Top holds FSM, opcode register, latency counter, result capture.
// TESTING (DEBOUNCE_CYCLES=4, ALU_LATENCY=1, NUM_OPS=10)
//  1 Reset: assert reset mid-cycle -> all outputs 0 immediately (async), state IDLE.
//  2 Button high 20 cycles -> one press, opcode 0->1, result_valid once 2 cycles later with alu_ans sampled.
//  3 Glitch: button high 3 cycles then low -> no opcode change, no result_valid.
//  4 Wrap: 10 clean presses from 0 -> opcode 1..9 then 0; 10 result_valid pulses.
//  5 load_en=1, load_op=7 with press same cycle -> opcode=7, one result_valid; load_op=12 -> load_err pulse, opcode unchanged.
//  6 load_en during WAIT -> ignored; reset asserted in WAIT -> no result_valid, opcode=0.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared types and opcode constants for the ALU op sequencer
package alu_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        CAPTURE = 2'd2
    } alu_seq_state_t;

    localparam int DEFAULT_NUM_OPS = 10;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_NOT = 4'd5;
    localparam logic [3:0] OP_SHL = 4'd6;
    localparam logic [3:0] OP_SHR = 4'd7;
    localparam logic [3:0] OP_INC = 4'd8;
    localparam logic [3:0] OP_DEC = 4'd9;

endpackage

// File: rtl/alu_op_sequencer_if.sv
// rtl/alu_op_sequencer_if.sv - board/ALU side signal bundle of the op sequencer
interface alu_op_sequencer_if #(
    parameter int DATA_WIDTH   = 8,
    parameter int OPCODE_WIDTH = 4
);
    logic                    button;
    logic                    load_en;
    logic [OPCODE_WIDTH-1:0] load_op;
    logic [DATA_WIDTH-1:0]   alu_ans;
    logic [OPCODE_WIDTH-1:0] opcode;
    logic [DATA_WIDTH-1:0]   result;
    logic                    result_valid;
    logic                    busy;
    logic                    load_err;

    modport master (
        output button, load_en, load_op, alu_ans,
        input  opcode, result, result_valid, busy, load_err
    );

    modport slave (
        input  button, load_en, load_op, alu_ans,
        output opcode, result, result_valid, busy, load_err
    );
endinterface

// File: rtl/button_debouncer.sv
// rtl/button_debouncer.sv - two-flop synchroniser, stability counter and press edge detect
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic btn_stable,
    output logic btn_press
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q;
    logic          btn_s_q;
    logic          stable_q, stable_d;
    logic          stable_dly_q;
    logic [CW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q      <= 1'b0;
            btn_s_q      <= 1'b0;
            stable_q     <= 1'b0;
            stable_dly_q <= 1'b0;
            cnt_q        <= '0;
        end else begin
            sync1_q      <= btn_raw;
            btn_s_q      <= sync1_q;
            stable_q     <= stable_d;
            stable_dly_q <= stable_q;
            cnt_q        <= cnt_d;
        end
    end

    // Any cycle where the synced level agrees with the accepted one restarts the count.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        if (btn_s_q != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = btn_s_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    assign btn_stable = stable_q;
    assign btn_press  = stable_q & ~stable_dly_q;
endmodule

// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - steps/loads the ALU opcode, waits out ALU latency, captures the answer
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH      = 8,
    parameter int OPCODE_WIDTH    = 4,
    parameter int NUM_OPS         = DEFAULT_NUM_OPS,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int ALU_LATENCY     = 1
) (
    input  logic clk,
    input  logic reset,
    alu_op_sequencer_if.slave bus
);
    localparam int WW = $clog2(ALU_LATENCY + 1);
    localparam logic [WW-1:0]         WCNT_INIT = WW'(ALU_LATENCY - 1);
    localparam logic [OPCODE_WIDTH:0] NUM_OPS_X = (OPCODE_WIDTH + 1)'(NUM_OPS);
    localparam logic [OPCODE_WIDTH-1:0] LAST_OP = OPCODE_WIDTH'(NUM_OPS - 1);

    alu_seq_state_t          state_q, state_d;
    logic [OPCODE_WIDTH-1:0] opcode_q, opcode_d;
    logic [WW-1:0]           wcnt_q, wcnt_d;
    logic [DATA_WIDTH-1:0]   result_q, result_d;
    logic                    result_valid_q, result_valid_d;
    logic                    load_err_q, load_err_d;
    logic                    btn_stable, btn_press, press;

    button_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
        .clk       (clk),
        .reset     (reset),
        .btn_raw   (bus.button),
        .btn_stable(btn_stable),
        .btn_press (btn_press)
    );

    assign press = btn_press & btn_stable;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            opcode_q       <= '0;
            wcnt_q         <= '0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            load_err_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            opcode_q       <= opcode_d;
            wcnt_q         <= wcnt_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
            load_err_q     <= load_err_d;
        end
    end

    // A load request always shadows a same-cycle press, even when the load is rejected.
    always_comb begin
        state_d        = state_q;
        opcode_d       = opcode_q;
        wcnt_d         = wcnt_q;
        result_d       = result_q;
        result_valid_d = 1'b0;
        load_err_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.load_en) begin
                    if ({1'b0, bus.load_op} < NUM_OPS_X) begin
                        opcode_d = bus.load_op;
                        wcnt_d   = WCNT_INIT;
                        state_d  = WAIT;
                    end else begin
                        load_err_d = 1'b1;
                    end
                end else if (press) begin
                    opcode_d = (opcode_q == LAST_OP) ? '0 : opcode_q + 1'b1;
                    wcnt_d   = WCNT_INIT;
                    state_d  = WAIT;
                end
            end
            WAIT: begin
                if (wcnt_q == '0) begin
                    state_d = CAPTURE;
                end else begin
                    wcnt_d = wcnt_q - 1'b1;
                end
            end
            CAPTURE: begin
                result_d       = bus.alu_ans;
                result_valid_d = 1'b1;
                state_d        = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.opcode       = opcode_q;
    assign bus.result       = result_q;
    assign bus.result_valid = result_valid_q;
    assign bus.load_err     = load_err_q;
    assign bus.busy         = (state_q == WAIT) || (state_q == CAPTURE);
endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb/tb_alu_op_sequencer.sv - scoreboard bench for alu_op_sequencer
module tb_alu_op_sequencer;
    import alu_pkg::*;

    localparam int DW   = 8;
    localparam int OW   = 4;
    localparam int NOPS = 10;
    localparam int DEB  = 4;
    localparam int LAT  = 1;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    alu_op_sequencer_if #(.DATA_WIDTH(DW), .OPCODE_WIDTH(OW)) bus ();

    alu_op_sequencer #(
        .DATA_WIDTH     (DW),
        .OPCODE_WIDTH   (OW),
        .NUM_OPS        (NOPS),
        .DEBOUNCE_CYCLES(DEB),
        .ALU_LATENCY    (LAT)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct {
        logic [OW-1:0] op;
        logic [DW-1:0] ans;
    } exp_t;

    exp_t          sb[$];
    int            n_checks = 0;
    int            n_pass = 0;
    int            rv_count = 0;
    int            lerr_count = 0;
    logic [OW-1:0] model_op;

    function automatic logic [DW-1:0] alu_f(input logic [OW-1:0] op);
        logic [DW-1:0] a, b;
        a = 8'h5A;
        b = 8'h33;
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            OP_NOT:  return ~a;
            OP_SHL:  return a << 1;
            OP_SHR:  return a >> 1;
            OP_INC:  return a + 8'd1;
            OP_DEC:  return a - 8'd1;
            default: return 8'hEE;
        endcase
    endfunction

    // One-cycle registered ALU, matching ALU_LATENCY = 1.
    always @(posedge clk) bus.alu_ans <= alu_f(bus.opcode);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (bus.result_valid) begin
            rv_count++;
            check("sb_nonempty", 32'(sb.size() > 0), 1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("result", bus.result, e.ans);
                check("opcode_at_valid", bus.opcode, e.op);
            end
        end
        if (bus.load_err) lerr_count++;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_step();
        model_op = (model_op == OW'(NOPS - 1)) ? '0 : model_op + 1'b1;
        sb.push_back('{op: model_op, ans: alu_f(model_op)});
    endtask

    task automatic press_btn(input int hi, input int lo);
        bus.button = 1'b1;
        tick(hi);
        bus.button = 1'b0;
        tick(lo);
    endtask

    initial begin
        int base, lbase, cyc;
        bus.button  = 1'b0;
        bus.load_en = 1'b0;
        bus.load_op = '0;
        model_op    = '0;

        // Reset state
        reset = 1'b1;
        tick(2);
        check("rst_opcode", bus.opcode, 0);
        check("rst_result", bus.result, 0);
        check("rst_valid", bus.result_valid, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_load_err", bus.load_err, 0);
        reset = 1'b0;
        tick(2);

        // Single clean press with latency checks
        base = rv_count;
        push_step();
        bus.button = 1'b1;
        cyc = 0;
        while (bus.opcode == 0 && cyc < 30) begin
            tick(1);
            cyc++;
        end
        check("press_latency_window", 32'(cyc >= DEB + 2 && cyc <= DEB + 4), 1);
        check("opcode_after_press", bus.opcode, 1);
        check("busy_in_wait", bus.busy, 1);
        check("no_valid_in_wait", bus.result_valid, 0);
        tick(1);
        check("busy_in_capture", bus.busy, 1);
        check("no_valid_in_capture", bus.result_valid, 0);
        tick(1);
        check("valid_after_capture", bus.result_valid, 1);
        check("idle_after_capture", bus.busy, 0);
        tick(12);
        bus.button = 1'b0;
        tick(12);
        check("one_valid_t2", rv_count - base, 1);
        check("opcode_held_t2", bus.opcode, 1);

        // Asynchronous reset mid-cycle
        #2 reset = 1'b1;
        #1;
        check("async_rst_opcode", bus.opcode, 0);
        check("async_rst_result", bus.result, 0);
        check("async_rst_busy", bus.busy, 0);
        tick(1);
        reset = 1'b0;
        model_op = '0;
        tick(2);

        // Glitch shorter than debounce window
        base = rv_count;
        bus.button = 1'b1;
        tick(3);
        bus.button = 1'b0;
        tick(15);
        check("glitch_opcode", bus.opcode, 0);
        check("glitch_no_valid", rv_count - base, 0);

        // Ten presses wrap the opcode back to 0
        base = rv_count;
        for (int i = 0; i < NOPS; i++) begin
            push_step();
            press_btn(8, 12);
            check("wrap_step_opcode", bus.opcode, model_op);
        end
        check("wrap_final_opcode", bus.opcode, 0);
        check("wrap_valid_count", rv_count - base, NOPS);

        // Load coinciding with a press: load wins
        base = rv_count;
        bus.button = 1'b1;
        cyc = 0;
        while (!dut.u_deb.btn_press && cyc < 30) begin
            tick(1);
            cyc++;
        end
        check("press_seen_t5", 32'(cyc < 30), 1);
        bus.load_en = 1'b1;
        bus.load_op = 4'd7;
        model_op = 4'd7;
        sb.push_back('{op: 4'd7, ans: alu_f(4'd7)});
        tick(1);
        bus.load_en = 1'b0;
        check("load_opcode", bus.opcode, 7);
        tick(10);
        bus.button = 1'b0;
        tick(12);
        check("load_one_valid", rv_count - base, 1);
        check("load_opcode_held", bus.opcode, 7);

        // Illegal load
        base  = rv_count;
        lbase = lerr_count;
        bus.load_en = 1'b1;
        bus.load_op = 4'd12;
        tick(1);
        bus.load_en = 1'b0;
        check("load_err_pulse", bus.load_err, 1);
        tick(1);
        check("load_err_clear", bus.load_err, 0);
        tick(5);
        check("bad_load_opcode", bus.opcode, 7);
        check("bad_load_err_count", lerr_count - lbase, 1);
        check("bad_load_no_valid", rv_count - base, 0);

        // Load during WAIT is dropped
        base = rv_count;
        push_step();
        bus.button = 1'b1;
        cyc = 0;
        while (!bus.busy && cyc < 30) begin
            tick(1);
            cyc++;
        end
        check("busy_seen_t6", 32'(cyc < 30), 1);
        bus.load_en = 1'b1;
        bus.load_op = 4'd3;
        tick(1);
        bus.load_en = 1'b0;
        tick(10);
        bus.button = 1'b0;
        tick(12);
        check("wait_load_opcode", bus.opcode, 8);
        check("wait_load_valid", rv_count - base, 1);

        // Reset during WAIT aborts the operation
        base = rv_count;
        bus.load_en = 1'b1;
        bus.load_op = 4'd5;
        tick(1);
        bus.load_en = 1'b0;
        check("abort_busy", bus.busy, 1);
        check("abort_opcode_loaded", bus.opcode, 5);
        #2 reset = 1'b1;
        #1;
        check("abort_rst_opcode", bus.opcode, 0);
        check("abort_rst_busy", bus.busy, 0);
        check("abort_rst_valid", bus.result_valid, 0);
        tick(1);
        reset = 1'b0;
        model_op = '0;
        tick(10);
        check("abort_no_valid", rv_count - base, 0);
        check("sb_drained", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
